// File: rtl/vga_fb_pkg.sv
// Shared frame-buffer constants and types, also used by the VGA timing generator.
// No logic; constants only.
// Not applicable.
package vga_fb_pkg;

  // Visible raster size
  localparam int H_ACT  = 640;
  localparam int V_ACT  = 480;

  // SRAM geometry: the top address bit selects one of the two frame buffers
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  // One SRAM operation per cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } phase_t;

  // RGB565 pixel as stored in the SRAM
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate plus buffer bit to an SRAM word address, with a raster bounds check.
// Latency: purely combinational.
// No handshake; the caller decides whether to act on in_range.
module fb_addr_calc
  import vga_fb_pkg::*;
(
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              buf_sel,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [ADDR_W-2:0] x_ext;
  logic [ADDR_W-2:0] y_ext;
  logic [ADDR_W-2:0] offset;

  assign x_ext = {{(ADDR_W-11){1'b0}}, x};
  assign y_ext = {{(ADDR_W-11){1'b0}}, y};

  // y*640 as two shifts: 640 = 512 + 128, so no multiplier is needed
  assign offset   = (y_ext << 9) + (y_ext << 7) + x_ext;
  assign addr     = {buf_sel, offset};
  assign in_range = (x < 10'(H_ACT)) && (y < 10'(V_ACT));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single owner of the frame-buffer SRAM: display reads have absolute priority, writer fills idle cycles, double-buffered.
// Latency: display read data valid 2 cycles after disp_req; accepted writes hit the SRAM the next cycle.
// Backpressure: writer stalls via wr_ready while the display requests or a buffer swap is pending.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_req,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_sel,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ce_n
);

  phase_t            phase;
  phase_t            phase_nxt;
  logic              swap_pending;
  logic              oor_rd_q;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              disp_in_range;
  logic              wr_in_range;
  logic              wr_accept;

  // Display always reads the front buffer
  fb_addr_calc u_disp_addr (
    .x        (disp_x),
    .y        (disp_y),
    .buf_sel  (front_sel),
    .addr     (disp_addr),
    .in_range (disp_in_range)
  );

  // Writer always targets the back buffer
  fb_addr_calc u_wr_addr (
    .x        (wr_x),
    .y        (wr_y),
    .buf_sel  (~front_sel),
    .addr     (wr_addr),
    .in_range (wr_in_range)
  );

  // Writer only gets cycles the display does not want, and none while a swap waits for frame start
  assign wr_ready  = rst_n & ~disp_req & ~swap_pending;
  assign wr_accept = wr_req & wr_ready;

  // Next-phase decision: in-range display read wins, then an in-range accepted write
  always_comb begin
    phase_nxt = S_IDLE;
    if (disp_req && disp_in_range) begin
      phase_nxt = S_RD;
    end else if (wr_accept && wr_in_range) begin
      phase_nxt = S_WR;
    end
  end

  // Phase register plus the SRAM address/data and display return path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= S_IDLE;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      sram_ce_n   <= 1'b1;
      oor_rd_q    <= 1'b0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      phase     <= phase_nxt;
      sram_ce_n <= 1'b0;
      // The buffer bit is frozen into sram_addr here, so a later swap cannot redirect this access
      if (phase_nxt == S_RD) begin
        sram_addr <= disp_addr;
      end else if (phase_nxt == S_WR) begin
        sram_addr  <= wr_addr;
        sram_wdata <= wr_data;
      end
      // Off-screen reads skip the SRAM but still answer on the same schedule, with black
      oor_rd_q    <= disp_req & ~disp_in_range;
      disp_rvalid <= (phase == S_RD) | oor_rd_q;
      if (phase == S_RD) begin
        disp_rdata <= sram_rdata;
      end else if (oor_rd_q) begin
        disp_rdata <= '0;
      end
    end
  end

  // Swap bookkeeping: arm on swap_req, flip the front buffer at the next frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= frame_start & swap_pending;
      if (frame_start && swap_pending) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // SRAM strobes decoded from the registered phase; WR->RD turnaround needs no gap cycle
  always_comb begin
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (phase)
      S_RD: sram_oe_n = 1'b0;
      S_WR: begin
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        disp_req;
  logic [9:0]  disp_x;
  logic [9:0]  disp_y;
  logic        disp_rvalid;
  logic [15:0] disp_rdata;
  logic        wr_req;
  logic        wr_ready;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_done;
  logic        front_sel;
  logic [19:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .disp_req    (disp_req),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .wr_req      (wr_req),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .front_sel   (front_sel),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ce_n   (sram_ce_n)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 0; disp_req = 0; disp_x = 0; disp_y = 0;
    wr_req = 0; wr_x = 0; wr_y = 0; wr_data = 0; swap_req = 0; sram_rdata = 0;
    #12;
    checks++; if (sram_ce_n !== 1'b1) begin errors++; $display("FAIL rst_ce_n: got %b exp 1", sram_ce_n); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready_in_reset: got %b exp 0", wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL idle_we_n: got %b exp 1", sram_we_n); end
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL idle_oe_n: got %b exp 1", sram_oe_n); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL idle_dq_oe: got %b exp 0", sram_dq_oe); end
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL idle_front_sel: got %b exp 0", front_sel); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL idle_wr_ready: got %b exp 1", wr_ready); end
    checks++; if (sram_ce_n !== 1'b0) begin errors++; $display("FAIL idle_ce_n: got %b exp 0", sram_ce_n); end
    checks++; if (disp_rvalid !== 1'b0 || swap_done !== 1'b0 || sram_addr !== 20'h0) begin
      errors++; $display("FAIL idle_misc: rvalid %b swap_done %b addr %h exp 0 0 0", disp_rvalid, swap_done, sram_addr); end
  endtask

  task automatic test_read();
    disp_req = 1; disp_x = 10'd3; disp_y = 10'd2;
    tick();
    disp_req = 0;
    checks++; if (sram_addr !== 20'h00503) begin errors++; $display("FAIL rd_addr: got %h exp 00503", sram_addr); end
    checks++; if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rd_strobes: oe_n %b we_n %b dq_oe %b exp 0 1 0", sram_oe_n, sram_we_n, sram_dq_oe); end
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b exp 0", disp_rvalid); end
    sram_rdata = 16'hABCD;
    tick();
    sram_rdata = 16'h0000;
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'hABCD) begin
      errors++; $display("FAIL rd_data: rvalid %b rdata %h exp 1 abcd", disp_rvalid, disp_rdata); end
    tick();
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL rd_valid_single: got %b exp 0", disp_rvalid); end
  endtask

  task automatic test_write_priority();
    disp_req = 1; disp_x = 10'd0; disp_y = 10'd0;
    wr_req = 1; wr_x = 10'd0; wr_y = 10'd1; wr_data = 16'h1234;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL prio_wr_ready: got %b exp 0", wr_ready); end
    tick();
    disp_req = 0;
    checks++; if (sram_oe_n !== 1'b0 || sram_addr !== 20'h00000) begin
      errors++; $display("FAIL prio_read_issued: oe_n %b addr %h exp 0 00000", sram_oe_n, sram_addr); end
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL prio_wr_ready_free: got %b exp 1", wr_ready); end
    tick();
    wr_req = 0;
    checks++; if (sram_addr !== 20'h80280 || sram_we_n !== 1'b0 || sram_wdata !== 16'h1234 || sram_dq_oe !== 1'b1 || sram_oe_n !== 1'b1) begin
      errors++; $display("FAIL wr_cycle: addr %h we_n %b wdata %h dq_oe %b oe_n %b exp 80280 0 1234 1 1",
                         sram_addr, sram_we_n, sram_wdata, sram_dq_oe, sram_oe_n); end
    tick();
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL wr_single: we_n %b dq_oe %b exp 1 0", sram_we_n, sram_dq_oe); end
  endtask

  task automatic test_swap();
    swap_req = 1;
    tick();
    swap_req = 0;
    wr_req = 1; wr_x = 10'd5; wr_y = 10'd5; wr_data = 16'h7777;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL swap_pending_ready: got %b exp 0", wr_ready); end
    tick();
    checks++; if (sram_we_n !== 1'b1 || front_sel !== 1'b0 || swap_done !== 1'b0) begin
      errors++; $display("FAIL swap_wait: we_n %b front %b done %b exp 1 0 0", sram_we_n, front_sel, swap_done); end
    wr_req = 0; frame_start = 1;
    tick();
    frame_start = 0;
    checks++; if (front_sel !== 1'b1 || swap_done !== 1'b1) begin
      errors++; $display("FAIL swap_take: front %b done %b exp 1 1", front_sel, swap_done); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_back: got %b exp 1", wr_ready); end
    disp_req = 1; disp_x = 0; disp_y = 0;
    tick();
    disp_req = 0;
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_pulse: got %b exp 0", swap_done); end
    checks++; if (sram_addr !== 20'h80000 || sram_oe_n !== 1'b0) begin
      errors++; $display("FAIL swap_rd_addr: addr %h oe_n %b exp 80000 0", sram_addr, sram_oe_n); end
    wr_req = 1; wr_x = 0; wr_y = 0; wr_data = 16'h0F0F;
    tick();
    wr_req = 0;
    checks++; if (sram_addr !== 20'h00000 || sram_we_n !== 1'b0) begin
      errors++; $display("FAIL swap_wr_addr: addr %h we_n %b exp 00000 0", sram_addr, sram_we_n); end
    tick();
  endtask

  task automatic test_out_of_range();
    disp_req = 1; disp_x = 10'd1; disp_y = 10'd1;
    tick();
    disp_req = 0; sram_rdata = 16'h5555;
    tick();
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'h5555) begin
      errors++; $display("FAIL oor_pre_read: rvalid %b rdata %h exp 1 5555", disp_rvalid, disp_rdata); end
    disp_req = 1; disp_x = 10'd640; disp_y = 10'd0; sram_rdata = 16'hFFFF;
    tick();
    disp_req = 0;
    checks++; if (sram_oe_n !== 1'b1 || disp_rvalid !== 1'b0) begin
      errors++; $display("FAIL oor_no_access: oe_n %b rvalid %b exp 1 0", sram_oe_n, disp_rvalid); end
    tick();
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'h0000) begin
      errors++; $display("FAIL oor_rd_black: rvalid %b rdata %h exp 1 0000", disp_rvalid, disp_rdata); end
    sram_rdata = 16'h0000;
    disp_req = 1; disp_x = 10'd0; disp_y = 10'd480;
    tick();
    disp_req = 0;
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL oor_y_no_access: oe_n %b exp 1", sram_oe_n); end
    wr_req = 1; wr_x = 10'd0; wr_y = 10'd480; wr_data = 16'hDEAD;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL oor_wr_ready: got %b exp 1", wr_ready); end
    tick();
    wr_req = 0;
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 16'h0000) begin
      errors++; $display("FAIL oor_y_black: rvalid %b rdata %h exp 1 0000", disp_rvalid, disp_rdata); end
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL oor_wr_dropped: we_n %b dq_oe %b exp 1 0", sram_we_n, sram_dq_oe); end
    tick();
  endtask

  // Front buffer is 1 here: reads land at 0x80000+, writes at 0x00000+
  task automatic test_back_to_back();
    int accepts;
    int writes;
    int reads;
    logic [19:0] exp_addr;
    accepts = 0; writes = 0; reads = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) begin
        disp_req = 1; disp_x = 10'(i); disp_y = 10'd7;
      end else begin
        disp_req = 0;
      end
      wr_req = 1; wr_x = 10'(i); wr_y = 10'd9; wr_data = 16'(i + 16'h100);
      #1;
      checks++; if (wr_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b exp %b", i, wr_ready, (i % 2 == 1)); end
      if (wr_req && wr_ready) accepts++;
      @(posedge clk);
      #1;
      if (disp_rvalid) reads++;
      if (sram_we_n == 1'b0) writes++;
      if (i % 2 == 0) begin
        exp_addr = 20'h80000 + 20'(7 * 640 + i);
        checks++; if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1 || sram_addr !== exp_addr) begin
          errors++; $display("FAIL b2b_rd[%0d]: oe_n %b we_n %b addr %h exp 0 1 %h", i, sram_oe_n, sram_we_n, sram_addr, exp_addr); end
      end else begin
        exp_addr = 20'(9 * 640 + i);
        checks++; if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b1 || sram_addr !== exp_addr || sram_wdata !== 16'(i + 16'h100)) begin
          errors++; $display("FAIL b2b_wr[%0d]: we_n %b oe_n %b dq_oe %b addr %h wdata %h exp 0 1 1 %h %h",
                             i, sram_we_n, sram_oe_n, sram_dq_oe, sram_addr, sram_wdata, exp_addr, 16'(i + 16'h100)); end
      end
    end
    disp_req = 0; wr_req = 0;
    tick();
    if (disp_rvalid) reads++;
    if (sram_we_n == 1'b0) writes++;
    checks++; if (writes != accepts || writes != 50) begin
      errors++; $display("FAIL b2b_write_count: writes %0d accepts %0d exp 50 50", writes, accepts); end
    checks++; if (reads != 50) begin errors++; $display("FAIL b2b_read_count: got %0d exp 50", reads); end
  endtask

  task automatic test_reset_mid_op();
    wr_req = 1; wr_x = 10'd2; wr_y = 10'd2; wr_data = 16'hBEEF;
    tick();
    wr_req = 0;
    checks++; if (sram_we_n !== 1'b0 || front_sel !== 1'b1) begin
      errors++; $display("FAIL mid_setup: we_n %b front %b exp 0 1", sram_we_n, front_sel); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1 || front_sel !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: we_n %b dq_oe %b ce_n %b front %b exp 1 0 1 0", sram_we_n, sram_dq_oe, sram_ce_n, front_sel); end
    checks++; if (sram_addr !== 20'h0 || sram_wdata !== 16'h0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_data: addr %h wdata %h ready %b exp 0 0 0", sram_addr, sram_wdata, wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (sram_ce_n !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL mid_recover: ce_n %b ready %b exp 0 1", sram_ce_n, wr_ready); end
  endtask

  task automatic test_swap_same_cycle();
    swap_req = 1; frame_start = 1;
    tick();
    swap_req = 0; frame_start = 0;
    checks++; if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
      errors++; $display("FAIL same_cycle_no_swap: front %b done %b exp 0 0", front_sel, swap_done); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_pending: ready %b exp 0", wr_ready); end
    swap_req = 1;
    tick();
    swap_req = 0; frame_start = 1;
    tick();
    frame_start = 0;
    checks++; if (front_sel !== 1'b1 || swap_done !== 1'b1) begin
      errors++; $display("FAIL same_cycle_take: front %b done %b exp 1 1", front_sel, swap_done); end
    tick();
    checks++; if (swap_done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL same_cycle_after: done %b ready %b exp 0 1", swap_done, wr_ready); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_priority();
    test_swap();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_op();
    test_swap_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
